// File: rtl/manip_pkg.sv
// Shared types and constants for the manip stage and its downstream consumers.
package manip_pkg;

    typedef logic [1:0] code_t;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } stats_state_t;

    localparam logic [31:0] SUM_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SUM_MIN = 32'h8000_0000;

endpackage

// File: rtl/manip_stats_sat_add32.sv
// Combinational signed 32+32 add that clamps to the 32-bit range and flags any clamp.
module sat_add32
    import manip_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        ovf
);

    logic [32:0] wide_s;

    // Sign-extended add; bits 32 and 31 disagree exactly when the result leaves 32-bit range
    always_comb begin
        wide_s = {a[31], a} + {b[31], b};
        if (wide_s[32] != wide_s[31]) begin
            ovf = 1'b1;
            sum = wide_s[32] ? SUM_MIN : SUM_MAX;
        end else begin
            ovf = 1'b0;
            sum = wide_s[31:0];
        end
    end

endmodule

// File: rtl/manip_stats.sv
// Windowed statistics over the manip output stream: per-code counts, saturating sum,
// optional min/max (built when MANIP_STATS_MINMAX_EN is defined).
module manip_stats
    import manip_pkg::*;
#(
    parameter int WINDOW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_code,
    input  logic [31:0] in_result,
    output logic        rpt_valid,
    input  logic        rpt_ready,
    output logic [7:0]  rpt_cnt0,
    output logic [7:0]  rpt_cnt1,
    output logic [7:0]  rpt_cnt2,
    output logic [7:0]  rpt_cnt3,
    output logic [31:0] rpt_sum,
    output logic        rpt_sat,
    output logic [31:0] rpt_min,
    output logic [31:0] rpt_max
);

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

    stats_state_t     state_r;
    stats_state_t     state_next_s;
    logic             in_ready_r;
    logic             rpt_valid_r;
    logic             accept_s;
    logic             clear_s;
    logic [3:0][7:0]  cnt_r;
    logic [7:0]       samp_cnt_r;
    logic [31:0]      sum_r;
    logic             sat_r;
    logic [31:0]      add_sum_s;
    logic             add_ovf_s;

    sat_add32 u_sat_add (
        .a   (sum_r),
        .b   (in_result),
        .sum (add_sum_s),
        .ovf (add_ovf_s)
    );

    // Next-state decode; in_ready_r is only ever high in ACCUM
    always_comb begin
        state_next_s = state_r;
        accept_s     = in_valid && in_ready_r;
        clear_s      = 1'b0;
        case (state_r)
            ACCUM: begin
                if (accept_s && (samp_cnt_r == LAST_IDX)) begin
                    state_next_s = REPORT;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    clear_s      = 1'b1;
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = REPORT;
                end
            end
            default: begin
                state_next_s = ACCUM;
            end
        endcase
    end

    // State, handshake flags and count/sum accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b0;
            rpt_valid_r <= 1'b0;
            cnt_r       <= '0;
            samp_cnt_r  <= 8'd0;
            sum_r       <= 32'd0;
            sat_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ACCUM);
            rpt_valid_r <= (state_next_s == REPORT);
            if (clear_s) begin
                cnt_r      <= '0;
                samp_cnt_r <= 8'd0;
                sum_r      <= 32'd0;
                sat_r      <= 1'b0;
            end else if (accept_s) begin
                cnt_r[in_code] <= cnt_r[in_code] + 8'd1;
                samp_cnt_r     <= samp_cnt_r + 8'd1;
                sum_r          <= add_sum_s;
                sat_r          <= sat_r | add_ovf_s;
            end
        end
    end

`ifdef MANIP_STATS_MINMAX_EN
    logic [31:0] min_r;
    logic [31:0] max_r;

    // Signed min/max; the first sample of each window loads both
    always_ff @(posedge clk) begin
        if (rst) begin
            min_r <= SUM_MAX;
            max_r <= SUM_MIN;
        end else if (clear_s) begin
            min_r <= SUM_MAX;
            max_r <= SUM_MIN;
        end else if (accept_s) begin
            if ((samp_cnt_r == 8'd0) || ($signed(in_result) < $signed(min_r))) begin
                min_r <= in_result;
            end
            if ((samp_cnt_r == 8'd0) || ($signed(in_result) > $signed(max_r))) begin
                max_r <= in_result;
            end
        end
    end

    assign rpt_min = min_r;
    assign rpt_max = max_r;
`else
    assign rpt_min = 32'h0000_0000;
    assign rpt_max = 32'h0000_0000;
`endif

    assign in_ready  = in_ready_r;
    assign rpt_valid = rpt_valid_r;
    assign rpt_cnt0  = cnt_r[0];
    assign rpt_cnt1  = cnt_r[1];
    assign rpt_cnt2  = cnt_r[2];
    assign rpt_cnt3  = cnt_r[3];
    assign rpt_sum   = sum_r;
    assign rpt_sat   = sat_r;

endmodule

// File: doc/manip_stats.md
# manip_stats

Downstream consumer of the `manip` stage. It accepts a stream of (`out` code, `result`) pairs over a valid/ready handshake and accumulates them over a fixed window of `WINDOW` samples. For each window it produces one statistics report: per-code counts, a saturating signed sum, and optionally the min/max of `result`. The report is held on an output handshake until the sink takes it, then the block clears and starts the next window.

## Interface
- `WINDOW`, 4: samples per report, legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  upstream `manip` pair is valid.
- `in_ready`  out  1  block accepts a pair this cycle.
- `in_code`  in  2  `manip.out` code, 0..3.
- `in_result`  in  32  `manip.result`, signed.
- `rpt_valid`  out  1  report available.
- `rpt_ready`  in  1  sink takes the report.
- `rpt_cnt0`..`rpt_cnt3`  out  8 each  count of samples with code 0..3.
- `rpt_sum`  out  32  signed saturating sum of `in_result`.
- `rpt_sat`  out  1  sum saturated at least once in this window (sticky).
- `rpt_min`, `rpt_max`  out  32 each  signed min/max of `in_result` in the window.

## Operation
- FSM states are `ACCUM` and `REPORT`. Reset enters `ACCUM`.
- `ACCUM`:
  - `in_ready`=1.
  - On accept (`in_valid && in_ready`): increment the `cnt[in_code]` counter and the sample counter, add `in_result` into the sum, and update min/max.
  - When an accept brings the sample counter to `WINDOW`, move to `REPORT`.
- `REPORT`:
  - `rpt_valid`=1 and `in_ready`=0. All `rpt_*` fields are held stable.
  - On `rpt_ready`, clear all accumulators and return to `ACCUM`.
- Sum arithmetic:
  - Compute a 33-bit signed add.
  - On overflow, clamp to 32'h7FFFFFFF; on underflow, clamp to 32'h80000000. Either case sets `rpt_sat`.
  - Once clamped, later samples keep adding from the clamped value.
- Min/max compares are signed. The first sample of a window loads both min and max.
- Per-code counts cannot overflow because they are bounded by `WINDOW` ≤ 255. Their total always equals `WINDOW` in a report.
- Reset values of outputs:
  - `in_ready`=0 while `rst` is high, 1 from the first cycle after release.
  - `rpt_valid`=0, counts=0, `rpt_sum`=0, `rpt_sat`=0.
  - `rpt_min`=32'h7FFFFFFF, `rpt_max`=32'h80000000.
- `rpt_*` outputs are the accumulator registers. During `ACCUM` they show partial values, which are meaningful only while `rpt_valid`=1.
- `rst` asserted mid-window or mid-report: the partial window or pending report is discarded and all outputs take their reset values on the next edge.

## Timing
- `in_ready` and `rpt_valid` are decoded from the registered state only. There is no combinational path from `in_valid` or `rpt_ready`.
- If the last sample of a window is accepted at edge N, `rpt_valid`=1 in the cycle after N, and the report includes that sample.
- Report handshake at edge M: accumulators are cleared and `in_ready`=1 in the cycle after M. Input is never accepted in the report-handshake cycle, so the minimum window-to-window gap is one idle cycle.
- `in_valid` asserted during `REPORT` is ignored. Upstream must hold the pair per valid/ready rules.
- With `WINDOW`=1, each accepted sample produces a report one cycle later.
- Throughput is `WINDOW` samples per `WINDOW`+1 cycles with a sink that is always ready.

## Configuration
- `MANIP_STATS_MINMAX_EN` defined: min/max registers and compare logic are built as described above.
- Undefined: no min/max logic. `rpt_min` and `rpt_max` are tied to 32'h0 at all times, including during reset. All other behaviour is unchanged.

## Structure
- Shared package `manip_pkg` holds:
  - `code_t` (logic [1:0]).
  - The state enum `stats_state_t {ACCUM, REPORT}`.
  - Constants `SUM_MAX`=32'h7FFFFFFF and `SUM_MIN`=32'h80000000.
- One sub-module, `sat_add32`: combinational signed 32+32 add producing a 32-bit saturated result plus an overflow flag. It is reusable elsewhere in the lab.
- All state lives in the top module `manip_stats`.

## Test plan
- Reset then idle: hold `rst` for 2 cycles, then check `in_ready`=0 during reset and 1 after. Check `rpt_valid`=0, counts 0, sum 0, min 32'h7FFFFFFF, max 32'h80000000 (0/0 with the macro off).
- Basic window (`WINDOW`=4): send (code,result) = (3,3), (0,8), (2,10), (2,6) back-to-back. Expect `rpt_valid` one cycle after the 4th accept with cnt0=1, cnt1=0, cnt2=2, cnt3=1, sum=27, min=3, max=10, sat=0.
- Backpressure: hold `rpt_ready`=0 for 5 cycles while `in_valid`=1. Expect `in_ready`=0 and the report unchanged for all 5 cycles. Then pulse `rpt_ready`; the next cycle has `in_ready`=1 and cleared accumulators.
- Saturation: results 32'h7FFFFFF0, 32'h00000100, -5, -5. Expect sum 32'h7FFFFFF5 with `rpt_sat`=1, because the clamp happens after the 2nd sample and the remaining samples add from the clamped value.
- Negative min/max: results -1, -100, 50, 0. Expect min=-100, max=50, sum=-51.
- Reset mid-window: accept 2 samples, assert `rst` for 1 cycle, then send 4 fresh samples. The report reflects only the 4 fresh samples.
